// File: rtl/tone_pkg.sv
// ---------------------------------------------------------------------------
// tone_pkg
// Shared types and constants for the tone scheduler:
//   note_t     - one melody entry: frequency word plus duration in ms
//   state_t    - scheduler states IDLE / MANUAL / NOTE / GAP
//   HZ_*       - frequency words for the three manual buttons
//   MELODY     - 16-entry melody table; an entry with dur_ms == 0 ends it
//   manual_hz  - maps a button vector to the highest-priority tone
// ---------------------------------------------------------------------------
package tone_pkg;

   localparam logic [14:0] HZ_LOW  = 15'd6000;
   localparam logic [14:0] HZ_MID  = 15'd15000;
   localparam logic [14:0] HZ_HIGH = 15'd30000;

   typedef struct packed {
      logic [14:0] hz;
      logic [9:0]  dur_ms;
   } note_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      MANUAL = 2'd1,
      NOTE   = 2'd2,
      GAP    = 2'd3
   } state_t;

   // Entry 2 is the terminator, so the melody is two notes long.  The
   // remaining slots are spare and hold terminators as well, so extending
   // the melody only means editing entries in place.
   localparam note_t MELODY [16] = '{
      '{HZ_LOW, 10'd3},
      '{HZ_MID, 10'd2},
      '{15'd0,  10'd0},
      '{15'd0,  10'd0},
      '{15'd0,  10'd0},
      '{15'd0,  10'd0},
      '{15'd0,  10'd0},
      '{15'd0,  10'd0},
      '{15'd0,  10'd0},
      '{15'd0,  10'd0},
      '{15'd0,  10'd0},
      '{15'd0,  10'd0},
      '{15'd0,  10'd0},
      '{15'd0,  10'd0},
      '{15'd0,  10'd0},
      '{15'd0,  10'd0}
   };

   // btn[2] beats btn[1] beats btn[0]; no button gives a zero word.
   function automatic logic [14:0] manual_hz(input logic [2:0] b);
      logic [14:0] h;
      h = 15'd0;
      if (b[2])
         h = HZ_HIGH;
      else if (b[1])
         h = HZ_MID;
      else if (b[0])
         h = HZ_LOW;
      return h;
   endfunction

endpackage

// File: rtl/tone_ms_tick.sv
// ---------------------------------------------------------------------------
// tone_ms_tick
// Free-running divider producing a one-cycle pulse every millisecond.
// Parameters:
//   CLK_HZ  input clock frequency; the pulse period is CLK_HZ/1000 cycles
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset
//   tick   out  one-cycle pulse per millisecond
// ---------------------------------------------------------------------------
module tone_ms_tick #(
   parameter int CLK_HZ = 100_000_000
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   // Clocks slower than 2 kHz degenerate to a pulse on every cycle.
   localparam int DIV = ((CLK_HZ / 1000) > 1) ? (CLK_HZ / 1000) : 1;
   localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] count;

   // Count 0..DIV-1 and register the wrap as the tick so the pulse is
   // glitch-free and exactly one cycle wide.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
         tick  <= 1'b0;
      end else if (count == LAST) begin
         count <= '0;
         tick  <= 1'b1;
      end else begin
         count <= count + CW'(1);
         tick  <= 1'b0;
      end
   end

endmodule

// File: rtl/tone_scheduler.sv
// ---------------------------------------------------------------------------
// tone_scheduler
// Chooses what the speaker tone generator plays: a manual tone while a button
// is held, otherwise a melody from tone_pkg::MELODY started by 'play', with a
// silent gap between notes.  Buttons always win over the melody.
// Parameters:
//   CLK_HZ  clock frequency, used to derive the 1 ms tick
//   GAP_MS  silent gap between melody notes, in ms
// Ports:
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   btn[2:0]  in   manual tone requests (asynchronous, active-high)
//   play      in   melody start request (asynchronous, rising edge)
//   hz        out  frequency word for the tone generator
//   tone_en   out  tone generator sounds while high
//   busy      out  high whenever the scheduler is not idle
//   note_idx  out  melody entry currently sounding or pending
// Build option:
//   TONE_SCHED_LOOP_EN  when defined the melody repeats from entry 0 instead
//                       of returning to IDLE at its end
// ---------------------------------------------------------------------------
module tone_scheduler
   import tone_pkg::*;
#(
   parameter int CLK_HZ = 100_000_000,
   parameter int GAP_MS = 20
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [2:0]  btn,
   input  logic        play,
   output logic [14:0] hz,
   output logic        tone_en,
   output logic        busy,
   output logic [3:0]  note_idx
);

   localparam int GAP_W = (GAP_MS > 0) ? $clog2(GAP_MS + 1) : 1;
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_MS);

   logic [2:0]       btn_meta, btn_sync;
   logic             play_meta, play_sync, play_prev;
   logic             tick;
   state_t           state, state_nxt;
   logic [3:0]       idx_nxt, idx_inc;
   logic [9:0]       dur_cnt, dur_nxt;
   logic [GAP_W-1:0] gap_cnt, gap_nxt;
   logic             btn_any, play_rise, last_entry;

   tone_ms_tick #(.CLK_HZ(CLK_HZ)) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick)
   );

   // Two-flop synchronizers for the asynchronous inputs, plus one extra
   // stage on play so its rising edge can be detected after synchronizing.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         btn_meta  <= 3'b000;
         btn_sync  <= 3'b000;
         play_meta <= 1'b0;
         play_sync <= 1'b0;
         play_prev <= 1'b0;
      end else begin
         btn_meta  <= btn;
         btn_sync  <= btn_meta;
         play_meta <= play;
         play_sync <= play_meta;
         play_prev <= play_sync;
      end
   end

   assign btn_any   = |btn_sync;
   assign play_rise = play_sync & ~play_prev;
   assign idx_inc   = note_idx + 4'd1;

   // The melody ends after entry 15 or when the following entry is a
   // terminator, so a terminator is never entered as a sounding note.
   assign last_entry = (note_idx == 4'd15) || (MELODY[idx_inc].dur_ms == 10'd0);

   // State register together with the note index and the two ms counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         note_idx <= 4'd0;
         dur_cnt  <= 10'd0;
         gap_cnt  <= '0;
      end else begin
         state    <= state_nxt;
         note_idx <= idx_nxt;
         dur_cnt  <= dur_nxt;
         gap_cnt  <= gap_nxt;
      end
   end

   // Next-state logic.  A held button aborts any melody; play edges only
   // matter in IDLE, and lose to a button arriving in the same cycle.  Note
   // and gap counters count down on ticks and hand over at the last tick.
   always_comb begin
      state_nxt = state;
      idx_nxt   = note_idx;
      dur_nxt   = dur_cnt;
      gap_nxt   = gap_cnt;
      case (state)
         IDLE: begin
            idx_nxt = 4'd0;
            if (btn_any) begin
               state_nxt = MANUAL;
            end else if (play_rise && (MELODY[0].dur_ms != 10'd0)) begin
               state_nxt = NOTE;
               dur_nxt   = MELODY[0].dur_ms;
            end
         end
         MANUAL: begin
            idx_nxt = 4'd0;
            if (!btn_any)
               state_nxt = IDLE;
         end
         NOTE: begin
            if (btn_any) begin
               state_nxt = MANUAL;
               idx_nxt   = 4'd0;
            end else if (tick) begin
               if (dur_cnt <= 10'd1) begin
                  state_nxt = GAP;
                  gap_nxt   = GAP_LOAD;
               end else begin
                  dur_nxt = dur_cnt - 10'd1;
               end
            end
         end
         GAP: begin
            if (btn_any) begin
               state_nxt = MANUAL;
               idx_nxt   = 4'd0;
            end else if (tick) begin
               if (gap_cnt <= GAP_W'(1)) begin
                  if (last_entry) begin
                     idx_nxt = 4'd0;
`ifdef TONE_SCHED_LOOP_EN
                     if (MELODY[0].dur_ms != 10'd0) begin
                        state_nxt = NOTE;
                        dur_nxt   = MELODY[0].dur_ms;
                     end else begin
                        state_nxt = IDLE;
                     end
`else
                     state_nxt = IDLE;
`endif
                  end else begin
                     state_nxt = NOTE;
                     idx_nxt   = idx_inc;
                     dur_nxt   = MELODY[idx_inc].dur_ms;
                  end
               end else begin
                  gap_nxt = gap_cnt - GAP_W'(1);
               end
            end
         end
         default: begin
            state_nxt = IDLE;
            idx_nxt   = 4'd0;
         end
      endcase
   end

   // Outputs decode straight from the state register, so the asynchronous
   // reset silences the speaker without waiting for a clock.  Manual tones
   // track the synchronized buttons live; the gap keeps the last note's word.
   always_comb begin
      hz      = 15'd0;
      tone_en = 1'b0;
      busy    = (state != IDLE);
      case (state)
         MANUAL: begin
            hz      = manual_hz(btn_sync);
            tone_en = 1'b1;
         end
         NOTE: begin
            hz      = MELODY[note_idx].hz;
            tone_en = 1'b1;
         end
         GAP: begin
            hz = MELODY[note_idx].hz;
         end
         default: begin
            hz = 15'd0;
         end
      endcase
   end

endmodule

// File: doc/tone_scheduler.md
TONE_SCHEDULER -- requirements
Module: tone_scheduler

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000, input clock frequency used to derive the 1 ms tick.
REQ-002 Parameter GAP_MS, default 20, silent gap in ms inserted between consecutive melody notes.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 rst_n  input  1  one clock; reset is asynchronous and active-low.
REQ-005 btn  input  3  manual tone requests, active-high (already inverted by the caller), asynchronous to clk.
REQ-006 play  input  1  melody start request, level-sampled, acted on at its rising edge.
REQ-007 hz  output  15  frequency word for the speaker tone generator.
REQ-008 tone_en  output  1  high when the tone generator shall sound.
REQ-009 busy  output  1  high in any state other than IDLE.
REQ-010 note_idx  output  4  index of the melody entry currently sounding or pending.

Function
REQ-011 btn and play SHALL each pass through a 2-flop synchronizer; all decisions use synchronized values (2-cycle input latency).
REQ-012 Manual priority: btn[2] > btn[1] > btn[0]; selected hz = 30000 / 15000 / 6000 respectively.
REQ-013 FSM states: IDLE, MANUAL, NOTE, GAP.
REQ-014 IDLE -> MANUAL when any synced btn high; else IDLE -> NOTE on play rising edge, note_idx=0, duration counter loaded.
REQ-015 MANUAL: hz follows current highest-priority btn every cycle, tone_en=1; -> IDLE the cycle after all btn low.
REQ-016 NOTE: hz = MELODY[note_idx].hz, tone_en=1; duration counter decrements on each 1 ms tick; at zero -> GAP.
REQ-017 GAP: tone_en=0, hz holds last note; after GAP_MS ticks, note_idx increments, -> NOTE.
REQ-018 An entry with dur_ms==0 is the terminator: on entering NOTE with it, -> IDLE, note_idx=0, tone_en never asserted for it.
REQ-019 note_idx reaching 15 after GAP SHALL wrap to 0 with the terminator rule applied to entry 0's successor logic unchanged (table of 16 always ends the melody at index 15 unless loop enabled).
REQ-020 Any synced btn high during NOTE or GAP aborts the melody: next cycle -> MANUAL, note_idx=0.
REQ-021 play rising edge during NOTE/GAP/MANUAL is ignored (no restart).
REQ-022 Simultaneous btn and play rising edge in IDLE: MANUAL wins.
REQ-023 1 ms tick: free-running counter of CLK_HZ/1000 cycles, one-cycle pulse; counter width derived via $clog2; runs in all states.

Reset
REQ-024 On rst_n low: state=IDLE, hz=0, tone_en=0, busy=0, note_idx=0, synchronizers and counters cleared, asynchronously.
REQ-025 Reset asserted mid-melody SHALL silence output immediately without waiting for a clock.

Configuration
REQ-026 Macro TONE_SCHED_LOOP_EN defined: reaching the terminator or index-15 end returns to note_idx=0 and continues in NOTE until a btn aborts.
REQ-027 Macro TONE_SCHED_LOOP_EN undefined: melody plays once and returns to IDLE (REQ-018/019).

Structure
REQ-028 Package tone_pkg SHALL hold: note_t (hz 15 bits, dur_ms 10 bits), MELODY 16-entry constant array, HZ_LOW=6000, HZ_MID=15000, HZ_HIGH=30000, state enum.
REQ-029 Sub-module tone_ms_tick SHALL generate the 1 ms pulse (parameter CLK_HZ).

Verification (bench uses CLK_HZ=1000 so tick every cycle, GAP_MS=2)
REQ-030 Reset release, no inputs -> hz=0, tone_en=0, busy=0 for 100 cycles.
REQ-031 btn=3'b101 held 10 cycles -> after 2-cycle sync, hz=30000, tone_en=1; release -> IDLE, tone_en=0 within 4 cycles.
REQ-032 play pulse, MELODY[0]={6000,3}, [1]={15000,2}, [2]={x,0} -> tone_en high 3, low 2, high 2, then IDLE with note_idx=0.
REQ-033 btn[1] asserted during NOTE of entry 1 -> MANUAL, hz=15000, note_idx=0; play during MANUAL ignored.
REQ-034 rst_n pulsed low mid-NOTE between clock edges -> tone_en=0 immediately, state IDLE after release.
REQ-035 With TONE_SCHED_LOOP_EN, REQ-032 stimulus -> entry 0 replays after entry 1's gap, busy stays 1 until btn pressed.
